// File: rtl/light_pkg.sv
// Shared lighting definitions: ramp state encoding, prescaler sizing and
// the common PWM code width used by pwm_gen and the brightness controller.
package light_pkg;

  localparam int PWM_VALUE_SIZE = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } ramp_state_t;

  function automatic int prescaler_width(
    input int unsigned mhz,
    input int unsigned us
  );
    int unsigned p;
    p = mhz * us;
    if (p <= 1) return 1;
    return $clog2(p);
  endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Step-period prescaler: counts 0..PERIOD-1 while enabled, pulses tick_o
// on the last count, and returns to 0 when cleared or disabled.
module ramp_tick_gen #(
  parameter int PERIOD = 4,
  parameter int CNT_W  = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign tick_o = en_i & w_last;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || !en_i) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/brightness_ramp.sv
// Fades value_o toward target_i by STEP_SIZE once per step period,
// saturating on the target; snap_i loads the target directly.
module brightness_ramp
  import light_pkg::*;
#(
  parameter int CLOCK_FREQ_MHZ = 100,
  parameter int STEP_PERIOD_US = 1000,
  parameter int PWM_VALUE_SIZE = light_pkg::PWM_VALUE_SIZE,
  parameter int STEP_SIZE      = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PWM_VALUE_SIZE-1:0] target_i,
  input  logic                      snap_i,
  output logic [PWM_VALUE_SIZE-1:0] value_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int P  = CLOCK_FREQ_MHZ * STEP_PERIOD_US;
  localparam int PW = prescaler_width(CLOCK_FREQ_MHZ, STEP_PERIOD_US);
  localparam int N  = PWM_VALUE_SIZE;

  localparam logic [N:0] STEP = (N+1)'(STEP_SIZE);

  ramp_state_t r_state;
  ramp_state_t w_state_nxt;
  logic [N-1:0] r_value;
  logic [N-1:0] w_value_nxt;
  logic         r_busy;
  logic         r_done;
  logic         w_done_nxt;
  logic         w_tick;
  logic         w_clr;
  logic         w_en;
  logic [N:0]   w_tgt;
  logic [N:0]   w_val;
  logic [N:0]   w_up_diff;
  logic [N:0]   w_dn_diff;

  assign w_tgt     = {1'b0, target_i};
  assign w_val     = {1'b0, r_value};
  assign w_up_diff = w_tgt - w_val;
  assign w_dn_diff = w_val - w_tgt;

  // Any state change (entry, reversal, landing) or snap restarts the period
  assign w_en  = (r_state != IDLE);
  assign w_clr = snap_i | (w_state_nxt != r_state);

  ramp_tick_gen #(
    .PERIOD (P),
    .CNT_W  (PW)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (w_clr),
    .en_i   (w_en),
    .tick_o (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_value_nxt = r_value;
    w_done_nxt  = 1'b0;
    if (snap_i) begin
      w_value_nxt = target_i;
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_tgt > w_val)      w_state_nxt = UP;
          else if (w_tgt < w_val) w_state_nxt = DOWN;
        end
        UP: begin
          if (w_tgt < w_val) begin
            w_state_nxt = DOWN;
          end else if (w_tgt == w_val) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (w_tick) begin
            if (w_up_diff > STEP) begin
              w_value_nxt = N'(w_val + STEP);
            end else begin
              w_value_nxt = target_i;
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        DOWN: begin
          if (w_tgt > w_val) begin
            w_state_nxt = UP;
          end else if (w_tgt == w_val) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (w_tick) begin
            if (w_dn_diff > STEP) begin
              w_value_nxt = N'(w_val - STEP);
            end else begin
              w_value_nxt = target_i;
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_value <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_value <= w_value_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign value_o = r_value;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule
